// File: rtl/game_sequencer.sv
// Game-phase controller: menu, Kong intro, play, hit pause, win/lose screens and barrel-throw scheduling.
// Outputs registered (1 clk latency); barrel_req held until barrel_ack; `INTRO_SKIP_EN lets a start press skip the intro.
module game_sequencer #(
   parameter int LIVES        = 3,
   parameter int MAX_BARRELS  = 4,
   parameter int THROW_PERIOD = 130_000_000,
   parameter int HIT_HOLD     = 65_000_000,
   parameter int END_HOLD     = 195_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start_btn,
   input  logic       animation,
   input  logic       hit,
   input  logic       win,
   input  logic       barrel_ack,
   input  logic       barrel_done,
   output logic       anim_rst,
   output logic       start_game,
   output logic       player_en,
   output logic       barrel_req,
   output logic       barrel_clear,
   output logic [2:0] lives,
   output logic [2:0] active_barrels,
   output logic [2:0] screen
);

   localparam int CW = 28;
   localparam logic [CW-1:0] ONE        = CW'(1);
   localparam logic [CW-1:0] THROW_LAST = CW'(THROW_PERIOD - 1);
   localparam logic [CW-1:0] HIT_LAST   = CW'(HIT_HOLD - 1);
   localparam logic [CW-1:0] END_LAST   = CW'(END_HOLD - 1);
   localparam logic [2:0]    LIVES_INIT = 3'(LIVES);
   localparam logic [2:0]    MAXB       = 3'(MAX_BARRELS);

   typedef enum logic [2:0] {
      S_MENU  = 3'd0,
      S_INTRO = 3'd1,
      S_PLAY  = 3'd2,
      S_HIT   = 3'd3,
      S_WIN   = 3'd4,
      S_LOSE  = 3'd5
   } state_t;

   state_t        state, state_nxt;
   logic          start_q;
   logic          start_edge;
   logic          armed, armed_nxt;
   logic          pending, pending_nxt;
   logic          ack_taken;
   logic          anim_rst_nxt, clear_nxt;
   logic [CW-1:0] throw_cnt, throw_nxt;
   logic [CW-1:0] hold_cnt, hold_nxt;
   logic [2:0]    lives_nxt, active_nxt;
`ifdef INTRO_SKIP_EN
   logic          intro_live;
`endif

   assign start_edge = start_btn & ~start_q;
   assign ack_taken  = (state == S_PLAY) && barrel_req && barrel_ack;

   always_comb begin
      state_nxt    = state;
      armed_nxt    = armed;
      pending_nxt  = pending;
      throw_nxt    = throw_cnt;
      hold_nxt     = hold_cnt + ONE;
      lives_nxt    = lives;
      anim_rst_nxt = 1'b0;
      clear_nxt    = 1'b0;

      case (state)
         S_MENU: begin
            hold_nxt = '0;
            if (start_edge) begin
               state_nxt    = S_INTRO;
               anim_rst_nxt = 1'b1;
               clear_nxt    = 1'b1;
               lives_nxt    = LIVES_INIT;
            end
         end
         S_INTRO: begin
            hold_nxt = '0;
            // Arm on a sampled 1 first so the animation's reset latency can't end the intro early.
            if (!armed && animation)
               armed_nxt = 1'b1;
            else if (armed && !animation)
               state_nxt = S_PLAY;
`ifdef INTRO_SKIP_EN
            if (intro_live && start_edge) begin
               state_nxt    = S_PLAY;
               anim_rst_nxt = 1'b1;
            end
`endif
         end
         S_PLAY: begin
            hold_nxt = '0;
            if (throw_cnt == THROW_LAST) begin
               throw_nxt   = '0;
               pending_nxt = 1'b1;
            end else begin
               throw_nxt = throw_cnt + ONE;
            end
            if (ack_taken)
               pending_nxt = 1'b0;
            if (win) begin
               state_nxt = S_WIN;
               clear_nxt = 1'b1;
            end else if (hit) begin
               clear_nxt = 1'b1;
               if (lives > 3'd1) begin
                  state_nxt = S_HIT;
                  lives_nxt = lives - 3'd1;
               end else begin
                  state_nxt = S_LOSE;
                  lives_nxt = 3'd0;
               end
            end
         end
         S_HIT: begin
            if (hold_cnt == HIT_LAST)
               state_nxt = S_PLAY;
         end
         S_WIN, S_LOSE: begin
            if (hold_cnt == END_LAST)
               state_nxt = S_MENU;
         end
         default: state_nxt = S_MENU;
      endcase

      if (state_nxt != state) begin
         hold_nxt = '0;
         if (state_nxt == S_PLAY) begin
            throw_nxt   = '0;
            pending_nxt = 1'b0;
         end
         if (state_nxt == S_INTRO)
            armed_nxt = 1'b0;
      end

      active_nxt = active_barrels;
      if (ack_taken && barrel_done)
         active_nxt = active_barrels;
      else if (ack_taken)
         active_nxt = active_barrels + 3'd1;
      else if (barrel_done && (active_barrels != 3'd0))
         active_nxt = active_barrels - 3'd1;
      if (clear_nxt)
         active_nxt = 3'd0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= S_MENU;
         start_q        <= 1'b0;
         armed          <= 1'b0;
         pending        <= 1'b0;
         throw_cnt      <= '0;
         hold_cnt       <= '0;
         lives          <= LIVES_INIT;
         active_barrels <= 3'd0;
         screen         <= 3'd0;
         anim_rst       <= 1'b0;
         barrel_clear   <= 1'b0;
         start_game     <= 1'b0;
         player_en      <= 1'b0;
         barrel_req     <= 1'b0;
      end else begin
         state          <= state_nxt;
         start_q        <= start_btn;
         armed          <= armed_nxt;
         pending        <= pending_nxt;
         throw_cnt      <= throw_nxt;
         hold_cnt       <= hold_nxt;
         lives          <= lives_nxt;
         active_barrels <= active_nxt;
         screen         <= state_nxt;
         anim_rst       <= anim_rst_nxt;
         barrel_clear   <= clear_nxt;
         start_game     <= (state_nxt == S_INTRO) || (state_nxt == S_PLAY) || (state_nxt == S_HIT);
         player_en      <= (state_nxt == S_PLAY);
         barrel_req     <= (state_nxt == S_PLAY) && pending_nxt && (active_nxt < MAXB);
      end
   end

`ifdef INTRO_SKIP_EN
   // Blocks the start edge that entered INTRO from also skipping it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         intro_live <= 1'b0;
      else
         intro_live <= (state == S_INTRO) && (state_nxt == S_INTRO);
   end
`endif

endmodule

// File: tb/tb_game_sequencer.sv
// Scoreboard bench for game_sequencer: directed stimulus pushes expected output events, a negedge monitor pops and checks them.
module tb_game_sequencer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start_btn = 1'b0;
   logic       animation = 1'b0;
   logic       hit = 1'b0;
   logic       win = 1'b0;
   logic       barrel_ack = 1'b0;
   logic       barrel_done = 1'b0;
   logic       anim_rst, start_game, player_en, barrel_req, barrel_clear;
   logic [2:0] lives, active_barrels, screen;

   int cyc = 0;
   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   game_sequencer #(
      .LIVES(2), .MAX_BARRELS(2), .THROW_PERIOD(10), .HIT_HOLD(5), .END_HOLD(8)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start_btn(start_btn), .animation(animation),
      .hit(hit), .win(win), .barrel_ack(barrel_ack), .barrel_done(barrel_done),
      .anim_rst(anim_rst), .start_game(start_game), .player_en(player_en),
      .barrel_req(barrel_req), .barrel_clear(barrel_clear), .lives(lives),
      .active_barrels(active_barrels), .screen(screen)
   );

   // Field value -1 means "don't care".
   typedef struct {
      string nm;
      int    cyc;
      int    scr, liv, act, ar, clr, req, pen, sg;
   } ev_t;

   ev_t exp_q[$];

   task automatic push_ev(input string nm, input int c, input int scr, input int liv, input int act,
                          input int ar, input int clr, input int req, input int pen, input int sg);
      ev_t e;
      e.nm = nm; e.cyc = c; e.scr = scr; e.liv = liv; e.act = act;
      e.ar = ar; e.clr = clr; e.req = req; e.pen = pen; e.sg = sg;
      exp_q.push_back(e);
   endtask

   function automatic bit fm(input int e, input int a);
      return (e < 0) || (e == a);
   endfunction

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // An event is any screen/active/req change, or any cycle with a pulse output high.
   int p_scr = 7, p_act = 7, p_req = 2;
   always @(negedge clk) begin : monitor
      ev_t e;
      if (int'(screen) != p_scr || int'(active_barrels) != p_act || int'(barrel_req) != p_req
          || anim_rst || barrel_clear) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_event cyc=%0d got screen=%0d lives=%0d active=%0d anim_rst=%0b clear=%0b req=%0b, required no event",
                     cyc, screen, lives, active_barrels, anim_rst, barrel_clear, barrel_req);
         end else begin
            e = exp_q.pop_front();
            if (!(fm(e.cyc, cyc) && fm(e.scr, int'(screen)) && fm(e.liv, int'(lives))
                  && fm(e.act, int'(active_barrels)) && fm(e.ar, int'(anim_rst))
                  && fm(e.clr, int'(barrel_clear)) && fm(e.req, int'(barrel_req))
                  && fm(e.pen, int'(player_en)) && fm(e.sg, int'(start_game)))) begin
               n_err++;
               $display("FAIL %s: got cyc=%0d scr=%0d liv=%0d act=%0d ar=%0b clr=%0b req=%0b pen=%0b sg=%0b; required cyc=%0d scr=%0d liv=%0d act=%0d ar=%0d clr=%0d req=%0d pen=%0d sg=%0d",
                        e.nm, cyc, screen, lives, active_barrels, anim_rst, barrel_clear, barrel_req,
                        player_en, start_game, e.cyc, e.scr, e.liv, e.act, e.ar, e.clr, e.req, e.pen, e.sg);
            end
         end
      end
      p_scr = int'(screen);
      p_act = int'(active_barrels);
      p_req = int'(barrel_req);
   end

   initial begin : stim
      int s, p, q;
      ev_t e;
      //       name                 cyc  scr liv act ar clr req pen sg
      push_ev("reset",              -1,  0,  2,  0,  0, 0,  0,  0,  0);
      step(3);
      rst_n = 1'b1;
      step(2);

      // Start held high for 20 cycles: exactly one edge, one anim_rst pulse.
      s = cyc;
      start_btn = 1'b1;
      push_ev("menu_to_intro",      s+1, 1,  2,  0,  1, 1,  0,  0,  1);
      step(4);
      animation = 1'b1;
      step(4);
      animation = 1'b0;
      push_ev("intro_to_play",      s+9, 2,  2,  0,  0, 0,  0,  1,  1);
      step(1);
      p = cyc;

      // Throw scheduling with acks delayed 3 cycles, saturation at MAX_BARRELS.
      push_ev("req1_rise",         p+10, 2,  2,  0,  0, 0,  1,  1,  1);
      step(11);
      start_btn = 1'b0;
      step(2);
      barrel_ack = 1'b1;
      push_ev("ack1",              p+14, 2,  2,  1,  0, 0,  0,  1,  1);
      step(1);
      barrel_ack = 1'b0;
      push_ev("req2_rise",         p+20, 2,  2,  1,  0, 0,  1,  1,  1);
      step(9);
      barrel_ack = 1'b1;
      push_ev("ack2_full",         p+24, 2,  2,  2,  0, 0,  0,  1,  1);
      step(1);
      barrel_ack = 1'b0;
      step(8);
      barrel_done = 1'b1;
      push_ev("done_reopens_req",  p+33, 2,  2,  1,  0, 0,  1,  1,  1);
      step(1);
      barrel_done = 1'b0;
      step(2);
      barrel_ack = 1'b1;
      barrel_done = 1'b1;
      push_ev("ack_done_same",     p+36, 2,  2,  1,  0, 0,  0,  1,  1);
      step(1);
      barrel_ack = 1'b0;
      barrel_done = 1'b0;

      // Two hits: pause then back to play, then lose and return to menu.
      step(1);
      hit = 1'b1;
      push_ev("hit1",              p+38, 3,  1,  0,  0, 1,  0,  0, -1);
      push_ev("hit_to_play",       p+43, 2,  1,  0,  0, 0,  0,  1,  1);
      step(1);
      hit = 1'b0;
      step(7);
      hit = 1'b1;
      push_ev("hit2_lose",         p+46, 5,  0,  0,  0, 1,  0,  0,  0);
      push_ev("lose_to_menu",      p+54, 0,  0,  0,  0, 0,  0,  0,  0);
      step(1);
      hit = 1'b0;
      step(10);

      // New game, win beats hit, then asynchronous reset mid-WIN.
      q = cyc;
      start_btn = 1'b1;
      push_ev("restart",            q+1, 1,  2,  0,  1, 1,  0,  0,  1);
      step(1);
      start_btn = 1'b0;
      animation = 1'b1;
      step(1);
      animation = 1'b0;
      push_ev("restart_play",       q+3, 2,  2,  0,  0, 0,  0,  1,  1);
      step(3);
      win = 1'b1;
      hit = 1'b1;
      push_ev("win_over_hit",       q+6, 4,  2,  0,  0, 1,  0,  0,  0);
      step(1);
      win = 1'b0;
      hit = 1'b0;
      step(2);
      push_ev("reset_mid_win",      q+8, 0,  2,  0,  0, 0,  0,  0,  0);
      rst_n = 1'b0;
      step(2);
      rst_n = 1'b1;
      step(15);

      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_cmp++;
         n_err++;
         $display("FAIL %s: got no event, required event at cyc=%0d screen=%0d", e.nm, e.cyc, e.scr);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
